// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 4x4 unsigned shift-and-add multiplier
// controller. It time-shares an external four_bit_adder: each RUN cycle it
// presents Acc and the selected multiplicand to the adder, and on the edge it
// shifts the adder's {Cout, Sum} together with Q one place to the right.
// After four iterations {Acc, Q} holds the 8-bit product. Product is then
// latched and Done pulses for one cycle.

module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   AddA,
  output logic [WIDTH-1:0]   AddB,
  output logic               AddCin,
  output logic               AddEnable,
  input  logic [WIDTH-1:0]   AddSum,
  input  logic               AddCout,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  // The controller is built around a 4-bit adder, so any other width is a
  // configuration error and is caught at elaboration.
  if (WIDTH != 4) begin : g_width_check
    $error("shift_add_multiplier: WIDTH must be 4 to match four_bit_adder");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   m_r;        // captured multiplicand
  logic [WIDTH-1:0]   acc_r;      // upper half of the partial product
  logic [WIDTH-1:0]   q_r;        // multiplier, shifting into lower product
  logic [1:0]         cnt_r;      // iteration index 0..3
  logic [2*WIDTH-1:0] product_r;
  logic               busy_r;
  logic               done_r;

  // The addend for one iteration is the multiplicand when the current
  // multiplier bit is set, otherwise zero.
  function automatic logic [WIDTH-1:0] partial_addend(
    input logic             q_lsb,
    input logic [WIDTH-1:0] mcand
  );
    logic [WIDTH-1:0] addend;
    if (q_lsb) begin
      addend = mcand;
    end else begin
      addend = '0;
    end
    return addend;
  endfunction

  // Control FSM and datapath registers; Busy/Done are registered alongside
  // the state so they are exactly "state is RUN" and "state is DONE".
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      m_r       <= '0;
      acc_r     <= '0;
      q_r       <= '0;
      cnt_r     <= 2'd0;
      product_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            m_r     <= A;
            q_r     <= B;
            acc_r   <= '0;
            cnt_r   <= 2'd0;
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end

        ST_RUN: begin
          // Shift {Cout, Sum, Q} right by one; the carry lands in Acc[3].
          acc_r <= {AddCout, AddSum[WIDTH-1:1]};
          q_r   <= {AddSum[0], q_r[WIDTH-1:1]};
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            product_r <= {AddCout, AddSum, q_r[WIDTH-1:1]};
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end

        ST_DONE: begin
          // A waiting Start is accepted straight from DONE for back-to-back use.
          if (Start) begin
            m_r     <= A;
            q_r     <= B;
            acc_r   <= '0;
            cnt_r   <= 2'd0;
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Adder drive derived from registered state only, so it is always defined
  // and reads all-zero while reset holds the registers cleared.
  always_comb begin
    AddA      = acc_r;
    AddB      = partial_addend(q_r[0], m_r);
    AddCin    = 1'b0;
    AddEnable = 1'b0;
    if (state_r == ST_RUN) begin
      AddEnable = 1'b1;
    end else begin
      AddEnable = 1'b0;
    end
  end

  assign Product = product_r;
  assign Busy    = busy_r;
  assign Done    = done_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier. A behavioural four_bit_adder
// closes the loop; expected products come from a*b computed here and are
// queued at accept time, then popped when Done is seen.

module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic       add_enable;
  logic [3:0] add_sum;
  logic       add_cout;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_q[$];

  shift_add_multiplier #(.WIDTH(4)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .Start     (start),
    .A         (a_in),
    .B         (b_in),
    .AddA      (add_a),
    .AddB      (add_b),
    .AddCin    (add_cin),
    .AddEnable (add_enable),
    .AddSum    (add_sum),
    .AddCout   (add_cout),
    .Product   (product),
    .Busy      (busy),
    .Done      (done)
  );

  // Behavioural four_bit_adder: outputs zero when disabled.
  assign {add_cout, add_sum} = add_enable ?
      ({1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin}) : 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One multiply with per-iteration adder checks. 'scramble' changes A/B and
  // pulses Start during RUN, which must not disturb the operation.
  task automatic run_mult(input logic [3:0] a, input logic [3:0] b,
                          input bit scramble, output bit saw_cout);
    int   busy_cnt;
    int   done_at;
    logic [7:0] exp_p;
    logic [3:0] exp_b;
    saw_cout = 1'b0;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb_q.push_back(8'(a) * 8'(b));
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 10 && done_at < 0; c++) begin
      if (done) begin
        done_at = c;
      end else begin
        if (busy && busy_cnt < 4) begin
          exp_b = b[busy_cnt] ? a : 4'd0;
          checks++;
          if (add_b !== exp_b || add_enable !== 1'b1 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL addb_iter%0d a=%h b=%h: got AddB=%h En=%b Cin=%b, want AddB=%h En=1 Cin=0",
                     busy_cnt + 1, a, b, add_b, add_enable, add_cin, exp_b);
          end
          if (add_cout === 1'b1) saw_cout = 1'b1;
          if (scramble && busy_cnt == 0) begin
            a_in = 4'hF;
            b_in = 4'hF;
          end
          if (scramble && busy_cnt == 1) start = 1'b1;
          if (scramble && busy_cnt == 2) start = 1'b0;
          busy_cnt++;
        end else if (busy) begin
          busy_cnt++;
        end
        @(posedge clk); #1;
      end
    end
    checks++;
    if (done_at != 4 || busy_cnt != 4) begin
      errors++;
      $display("FAIL latency a=%h b=%h: got done_at=%0d busy_cycles=%0d, want 4 and 4",
               a, b, done_at, busy_cnt);
    end
    if (done_at >= 0) begin
      exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      checks++;
      if (product !== exp_p || busy !== 1'b0) begin
        errors++;
        $display("FAIL product a=%h b=%h: got %h busy=%b, want %h busy=0",
                 a, b, product, busy, exp_p);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || product !== exp_p) begin
        errors++;
        $display("FAIL done_pulse a=%h b=%h: got done=%b product=%h, want done=0 product=%h",
                 a, b, done, product, exp_p);
      end
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 4'h0;
    b_in  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (product !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0 || add_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got P=%h busy=%b done=%b AddA=%h AddB=%h Cin=%b En=%b, want all 0",
               product, busy, done, add_a, add_b, add_cin, add_enable);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    bit cout_seen;
    run_mult(4'h7, 4'h3, 1'b0, cout_seen);
  endtask

  task automatic test_max();
    bit cout_seen;
    run_mult(4'hF, 4'hF, 1'b0, cout_seen);
    checks++;
    if (cout_seen !== 1'b1) begin
      errors++;
      $display("FAIL max_cout: got cout_seen=%b, want 1", cout_seen);
    end
  endtask

  task automatic test_hold_and_zero();
    bit cout_seen;
    run_mult(4'h9, 4'hB, 1'b0, cout_seen);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (product !== 8'h63 || busy !== 1'b0) begin
      errors++;
      $display("FAIL product_hold: got %h busy=%b, want 63 busy=0", product, busy);
    end
    run_mult(4'h0, 4'hF, 1'b0, cout_seen);
  endtask

  task automatic test_back_to_back();
    int   dones;
    int   done_cyc[3];
    logic [7:0] exp_p;
    a_in  = 4'h5;
    b_in  = 4'h5;
    start = 1'b1;
    dones = 0;
    for (int k = 0; k < 3; k++) sb_q.push_back(8'h19);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_reaccept: got busy=%b at cycle 6, want 1", busy);
        end
      end
      if (done) begin
        if (dones < 3) done_cyc[dones] = c;
        dones++;
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++;
        if (product !== exp_p) begin
          errors++;
          $display("FAIL b2b_product: got %h, want %h", product, exp_p);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dones != 3 || done_cyc[0] != 5 || done_cyc[1] != 10 || done_cyc[2] != 15) begin
      errors++;
      $display("FAIL b2b_period: got dones=%0d at %0d,%0d,%0d, want 3 at 5,10,15",
               dones, done_cyc[0], done_cyc[1], done_cyc[2]);
    end
    while (sb_q.size() > 0) void'(sb_q.pop_front());
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_operand_change();
    bit cout_seen;
    run_mult(4'h3, 4'h4, 1'b1, cout_seen);
  endtask

  task automatic test_reset_mid_run();
    bit cout_seen;
    bit done_seen;
    a_in  = 4'hA;
    b_in  = 4'hA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00 ||
        add_enable !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got busy=%b done=%b P=%h En=%b AddA=%h AddB=%h, want all 0",
               busy, done, product, add_enable, add_a, add_b);
    end
    #2 rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_abort: got activity=%b P=%h, want 0 and 00", done_seen, product);
    end
    run_mult(4'h2, 4'h6, 1'b0, cout_seen);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 4'h0;
    b_in  = 4'h0;
    test_reset();
    test_basic();
    test_max();
    test_hold_and_zero();
    test_back_to_back();
    test_operand_change();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
